// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its BCD debug channel.
package regfile_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } dbg_state_t;

    // Double-dabble correction: a digit of 5..9 would carry incorrectly after the shift.
    function automatic logic [BCD_DIGIT_W-1:0] bcd_add3(input logic [BCD_DIGIT_W-1:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one bit per falling edge; digits above
// BCD_DIGITS are dropped and flagged through the sticky overflow bit.
module bin2bcd_seq
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BCD_DIGITS = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_start,
    input  logic [DATA_WIDTH-1:0]             i_value,
    output logic                              o_busy,
    output logic                              o_valid,
    output logic [BCD_DIGIT_W*BCD_DIGITS-1:0] o_bcd,
    output logic                              o_ovf
);

    localparam int BW = BCD_DIGIT_W * BCD_DIGITS;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    dbg_state_t               r_state;
    logic [DATA_WIDTH-1:0]    r_bin;
    logic [BW-1:0]            r_acc;
    logic                     r_ovf;
    logic [CW-1:0]            r_cnt;

    logic [BW-1:0]            w_adj;
    logic [BW+DATA_WIDTH:0]   w_shift;
    logic                     w_carry;
    logic [BW-1:0]            w_acc_nxt;
    logic [DATA_WIDTH-1:0]    w_bin_nxt;

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < BCD_DIGITS; i++)
            w_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd_add3(r_acc[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end

    // The bit leaving the top digit is the only trace of the dropped hundreds-and-up value.
    assign w_shift   = {w_adj, r_bin, 1'b0};
    assign w_carry   = w_shift[BW+DATA_WIDTH];
    assign w_acc_nxt = w_shift[BW+DATA_WIDTH-1:DATA_WIDTH];
    assign w_bin_nxt = w_shift[DATA_WIDTH-1:0];

    assign o_busy = (r_state == SHIFT);

    always_ff @(negedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            o_valid <= 1'b0;
            o_bcd   <= '0;
            o_ovf   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_bin   <= i_value;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= CW'(DATA_WIDTH);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bin <= w_bin_nxt;
                    r_acc <= w_acc_nxt;
                    r_ovf <= r_ovf | w_carry;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        o_bcd   <= w_acc_nxt;
                        o_ovf   <= r_ovf | w_carry;
                        o_valid <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional hardwired x0,
// write-to-read bypass and a BCD debug channel on an extra internal read port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int NUM_RD_PORTS  = 2,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1,
    parameter int BCD_DIGITS    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rg_wrt_en,
    input  logic [ADDRESS_WIDTH-1:0]             rg_wrt_dest,
    input  logic [DATA_WIDTH-1:0]                rg_wrt_data,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rg_rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rg_rd_data,
    input  logic                                 dbg_start,
    input  logic [ADDRESS_WIDTH-1:0]             dbg_sel,
    output logic                                 dbg_busy,
    output logic                                 dbg_valid,
    output logic [BCD_DIGIT_W*BCD_DIGITS-1:0]    dbg_bcd,
    output logic                                 dbg_ovf
);

    localparam logic [ADDRESS_WIDTH:0] W_NREGS = (ADDRESS_WIDTH+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    // Index NUM_RD_PORTS is the debug snapshot port, so it shares read semantics exactly.
    logic [NUM_RD_PORTS:0][ADDRESS_WIDTH-1:0] w_addr;
    logic [NUM_RD_PORTS:0][DATA_WIDTH-1:0]    w_data;
    logic                                     w_wr_ok;

    function automatic logic addr_ok(input logic [ADDRESS_WIDTH-1:0] a);
        return ({1'b0, a} < W_NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_addr     = {dbg_sel, rg_rd_addr};
    assign rg_rd_data = w_data[NUM_RD_PORTS-1:0];
    assign w_wr_ok    = rg_wrt_en && addr_ok(rg_wrt_dest);

    always_comb begin
        w_data = '0;
        for (int k = 0; k <= NUM_RD_PORTS; k++) begin
            if (!addr_ok(w_addr[k]))
                w_data[k] = '0;
            else if ((BYPASS != 0) && rg_wrt_en && !rst && (w_addr[k] == rg_wrt_dest))
                w_data[k] = rg_wrt_data;
            else
                w_data[k] = r_regs[w_addr[k]];
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[rg_wrt_dest] <= rg_wrt_data;
        end
    end

    bin2bcd_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (dbg_start),
        .i_value (w_data[NUM_RD_PORTS]),
        .o_busy  (dbg_busy),
        .o_valid (dbg_valid),
        .o_bcd   (dbg_bcd),
        .o_ovf   (dbg_ovf)
    );

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the processor's 2-read/1-write register file.
- Adds a configurable number of read ports, optional hardwired-zero x0 and optional write-to-read bypass.
- Adds a sequential binary-to-BCD debug channel that converts any selected register for the board's seven-segment displays. This replaces fixed per-register /10 and %10 divider logic.
- Sits in the datapath between decode and ALU, clocked like the existing register file.

Parameters:
DATA_WIDTH, 32, bits per register
ADDRESS_WIDTH, 5, register address bits
NUM_REGS, 32, implemented registers (<= 2**ADDRESS_WIDTH)
NUM_RD_PORTS, 2, number of combinational read ports
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
BCD_DIGITS, 2, decimal digits produced by the debug converter

Ports:
clk  in  1  clock
rst  in  1  reset
rg_wrt_en  in  1  write enable
rg_wrt_dest  in  ADDRESS_WIDTH  write address
rg_wrt_data  in  DATA_WIDTH  write data
rg_rd_addr  in  NUM_RD_PORTS*ADDRESS_WIDTH  packed read addresses, port k at [k*AW +: AW]
rg_rd_data  out  NUM_RD_PORTS*DATA_WIDTH  packed read data, port k at [k*DW +: DW]
dbg_start  in  1  request conversion of register dbg_sel
dbg_sel  in  ADDRESS_WIDTH  register to convert
dbg_busy  out  1  conversion in progress
dbg_valid  out  1  one-cycle pulse, dbg_bcd/dbg_ovf updated
dbg_bcd  out  4*BCD_DIGITS  BCD digits, least significant digit at [3:0]
dbg_ovf  out  1  value >= 10**BCD_DIGITS

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Every flop updates on the falling edge of clk, matching the single-cycle processor timing.
- Reset:
  - At a falling edge with rst=1, all registers clear to 0 and the debug FSM goes to IDLE.
  - Reset values: dbg_bcd=0, dbg_ovf=0, dbg_valid=0, dbg_busy=0.
  - rst has priority over write and over dbg_start.
  - rst during a conversion aborts it; no dbg_valid pulse is produced.
- Write:
  - When rg_wrt_en=1 and rst=0, register[rg_wrt_dest] <= rg_wrt_data.
  - The write is ignored if rg_wrt_dest >= NUM_REGS.
  - The write is ignored if ZERO_REG=1 and rg_wrt_dest=0.
- Read (combinational, every port independent):
  - Returns 0 if the address >= NUM_REGS, or if ZERO_REG=1 and the address is 0.
  - Otherwise, if BYPASS=1, rg_wrt_en=1, rst=0 and the address equals rg_wrt_dest, returns rg_wrt_data.
  - Otherwise returns the stored value.
- Debug FSM (states IDLE, SHIFT):
  - IDLE:
    - dbg_start=1 is sampled at edge E0.
    - The snapshot is the value read port semantics would return for dbg_sel, so bypass applies.
    - The snapshot loads into the shift register, BCD accumulator and ovf are cleared, counter <= DATA_WIDTH, state goes to SHIFT.
  - SHIFT, once per edge (double dabble):
    - Every BCD digit >= 5 has 3 added.
    - The {bcd, binary} vector shifts left by 1.
    - The bit shifted out of the top digit ORs into a sticky ovf.
    - The counter decrements.
  - Last shift, edge E0+DATA_WIDTH (E32 by default):
    - dbg_bcd and dbg_ovf are registered from the accumulator.
    - dbg_valid=1 for exactly one cycle; state goes to IDLE.
  - dbg_busy=1 exactly while in SHIFT.
  - dbg_start while busy, including at the completing edge, is ignored; a new request is accepted at E0+DATA_WIDTH+1 at the earliest.
  - dbg_bcd and dbg_ovf hold their last result until the next completion or reset.
  - Register writes during a conversion do not affect the in-flight result.
- Width rules:
  - Conversion is unsigned.
  - When dbg_ovf=1, dbg_bcd holds the value mod 10**BCD_DIGITS.

Decomposition:
- regfile_pkg:
  - typedef enum {IDLE, SHIFT} for the debug state.
  - Constant BCD_DIGIT_W=4.
  - Function for the add-3 digit adjust.
- Sub-module bin2bcd_seq holds the FSM, counter and double-dabble datapath, parameterised by DATA_WIDTH and BCD_DIGITS.
- regfile_mp holds the storage, read muxes and bypass, and instantiates bin2bcd_seq.

Test Plan:
- Reset clear: write 0xDEAD to r5, then rst=1 for one edge -> all ports read 0 for every address; dbg_busy=0, dbg_bcd=0.
- Zero register and bypass: write 0x1234 to r0 -> r0 reads 0. With rg_wrt_en=1, dest=r7, data=0x55 and port 1 addressing r7 in the same cycle -> port 1 shows 0x55 before the edge. With BYPASS=0 -> port 1 shows the old value.
- Multi-port: NUM_RD_PORTS=4, r1..r4 = 10,20,30,40, all ports read distinct addresses -> each port returns its own value independently.
- Debug in-range: r18=47, dbg_start with dbg_sel=18 -> dbg_busy high for 32 edges; dbg_valid pulses once at E32; dbg_bcd=0x47, dbg_ovf=0. A second dbg_start at E10 is ignored.
- Debug overflow and snapshot: r20=123, start conversion, write r20=5 at E3 -> result dbg_bcd=0x23, dbg_ovf=1. A new start at E33 then yields 0x05, dbg_ovf=0.
- Reset mid-conversion: rst=1 at E15 -> no dbg_valid pulse; dbg_busy=0, dbg_bcd=0, dbg_ovf=0 after that edge.
